accum_multichan: RTL

ACCUM_MULTICHAN -- requirements
Module: accum_multichan

---
 rtl/accum_multichan.sv | 116 +++++++++++
 1 files changed

// File: rtl/accum_multichan.sv
// Multi-channel signed accumulator with a two-stage valid/ready pipeline.
// Stage A holds the request; stage B updates the bank and the output register.
module accum_multichan #(
  parameter int N   = 16,
  parameter int CH  = 4,
  parameter int SAT = 0,
  localparam int CW = $clog2(CH)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          InValid,
  output logic          InReady,
  input  logic [CW-1:0] Chan,
  input  logic [1:0]    Op,
  input  logic [N-1:0]  Data,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [CW-1:0] OutChan,
  output logic [N-1:0]  OutZ,
  output logic          OutOverflow,
  output logic [CH-1:0] OvfSticky,
  input  logic [CH-1:0] OvfClr
);

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_LOAD, OP_CLR} op_e;

  typedef struct packed {
    logic [CW-1:0] chan;
    op_e           op;
    logic [N-1:0]  data;
  } req_t;

  req_t          a_req;
  logic          a_valid;
  logic [N-1:0]  bank [CH];

  logic          stall, accept, wr;
  logic [N-1:0]  acc, opb, sum, res;
  logic          cin, ovf;
  logic [CH-1:0] set_mask;

  assign stall   = OutValid && !OutReady;
  assign InReady = !a_valid || !stall;
  assign accept  = InValid && InReady;
  assign wr      = a_valid && !stall;

  // Bank is written at the same edge the result is presented, so a
  // back-to-back op on the same channel reads the fresh value directly.
  always_comb begin
    acc = bank[a_req.chan];
    opb = a_req.data;
    cin = 1'b0;
    if (a_req.op == OP_SUB) begin
      opb = ~a_req.data;
      cin = 1'b1;
    end
    sum = acc + opb + {{(N-1){1'b0}}, cin};
    res = sum;
    ovf = 1'b0;
    case (a_req.op)
      OP_ADD, OP_SUB: begin
        ovf = (acc[N-1] == opb[N-1]) && (sum[N-1] != acc[N-1]);
        if (ovf && SAT != 0)
          res = acc[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end
      OP_LOAD: res = a_req.data;
      default: res = '0;
    endcase
  end

  always_comb begin
    set_mask = '0;
    if (wr && ovf) set_mask[a_req.chan] = 1'b1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      a_valid <= 1'b0;
      a_req   <= '0;
    end else begin
      if (accept) a_req <= '{chan: Chan, op: op_e'(Op), data: Data};
      a_valid <= accept || (a_valid && stall);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      OutValid    <= 1'b0;
      OutChan     <= '0;
      OutZ        <= '0;
      OutOverflow <= 1'b0;
    end else if (!stall) begin
      OutValid <= a_valid;
      if (a_valid) begin
        OutChan     <= a_req.chan;
        OutZ        <= res;
        OutOverflow <= ovf;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < CH; i++) bank[i] <= '0;
    end else if (wr) begin
      bank[a_req.chan] <= res;
    end
  end

  // A set on the same edge as a clear wins.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) OvfSticky <= '0;
    else       OvfSticky <= (OvfSticky & ~OvfClr) | set_mask;
  end

endmodule
